// File: rtl/uart_out_arbiter.sv
// Round-robin console arbiter feeding a character FIFO toward one UART sink.
// Optional line locking (hold a requester until newline) with UART_ARB_LINE_LOCK_EN.
module uart_out_arbiter #(
    parameter int NREQ         = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [8*NREQ-1:0]             req_ch,
    output logic [NREQ-1:0]               req_ready,
    output logic                          out_valid,
    output logic [7:0]                    out_ch,
    output logic [2:0]                    out_src,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

`ifdef UART_ARB_LINE_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [7:0]    ch_mem  [FIFO_DEPTH];
    logic [2:0]    src_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [0:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] lock_idx;
    logic [CW-1:0] idle_cnt;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] sel;
    logic          grant_any;
    logic [7:0]    grant_ch;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel       = '0;
        if (state == S_LOCKED) begin
            grant_any = 1'b1;
            grant_idx = lock_idx;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                sel = IW'((int'(last) + k) % NREQ);
                if (!grant_any && req_valid[sel]) begin
                    grant_any = 1'b1;
                    grant_idx = sel;
                end
            end
        end
    end

    always_comb begin
        grant_ch = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i))
                grant_ch = req_ch[8*i +: 8];
        end
    end

    // Ready is a pure grant/space decision so requesters can rely on it.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = reset && grant_any && !full
                           && (grant_idx == IW'(i));
        end
    end

    assign push = |(req_valid & req_ready);
    assign pop  = !empty && out_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            ch_mem[wr_ptr]  <= grant_ch;
            src_mem[wr_ptr] <= 3'(grant_idx);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid  = !empty;
    assign out_ch     = empty ? 8'h00 : ch_mem[rd_ptr];
    assign out_src    = empty ? 3'd0 : src_mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last     <= IW'(NREQ - 1);
            state    <= S_IDLE;
            lock_idx <= '0;
            idle_cnt <= '0;
        end else begin
            if (push)
                last <= grant_idx;
            unique case (state)
                S_IDLE: begin
                    if (LOCK_EN && push && grant_ch != 8'h0A) begin
                        state    <= S_LOCKED;
                        lock_idx <= grant_idx;
                        idle_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (push && grant_ch == 8'h0A) begin
                        state    <= S_IDLE;
                        idle_cnt <= '0;
                    end else if (req_valid[lock_idx]) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state    <= S_IDLE;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Scoreboard bench for uart_out_arbiter: model predicts grants and FIFO
// contents, monitor compares every character leaving the sink port.
module tb_uart_out_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int LTO   = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_ch = '0;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [7:0]        out_ch;
    logic [2:0]        out_src;
    logic              out_ready = 1'b0;
    logic [3:0]        fifo_count;

    uart_out_arbiter #(
        .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .LOCK_TIMEOUT(LTO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .out_valid(out_valid), .out_ch(out_ch), .out_src(out_src),
        .out_ready(out_ready), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [10:0]     sbq[$];
    logic [10:0]     out_log[$];
    logic [7:0]      chq[NREQ][$];
    logic [NREQ-1:0] en = '0;
    logic [NREQ-1:0] acc_vec = '0;

    int occ = 0;
    int m_last = NREQ - 1;
    bit m_locked = 1'b0;
    int m_lidx = 0;
    int m_idle = 0;

    logic [NREQ-1:0] m_exp;
    logic [NREQ-1:0] m_acc;
    logic [7:0]      m_ch;
    int  m_g;
    bit  m_has;
    bit  m_pop;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare sink side against the expected-output queue.
    always @(negedge clock) begin
        chk("fifo_count", 32'(fifo_count), 32'(occ));
        chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
        if (out_valid && sbq.size() > 0) begin
            chk("out_ch", 32'(out_ch), 32'(sbq[0][7:0]));
            chk("out_src", 32'(out_src), 32'(sbq[0][10:8]));
            if (out_ready) begin
                out_log.push_back(sbq[0]);
                void'(sbq.pop_front());
            end
        end
    end

    // Reference model: who should be ready, what gets accepted.
    always @(negedge clock) begin
        #1;
        m_exp = '0;
        m_acc = '0;
        m_has = 1'b0;
        m_g   = 0;
        m_ch  = 8'h00;
        m_pop = 1'b0;
        if (reset) begin
            if (m_locked) begin
                m_has = 1'b1;
                m_g   = m_lidx;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!m_has && req_valid[(m_last + k) % NREQ]) begin
                        m_has = 1'b1;
                        m_g   = (m_last + k) % NREQ;
                    end
                end
            end
            if (m_has && occ < DEPTH)
                m_exp[m_g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(m_exp));
        if (reset) begin
            m_acc = req_valid & m_exp;
            m_pop = (occ > 0) && out_ready;
            if (m_acc != '0) begin
                m_ch = req_ch[8*m_g +: 8];
                sbq.push_back({3'(m_g), m_ch});
                m_last = m_g;
            end
`ifdef UART_ARB_LINE_LOCK_EN
            if (m_locked) begin
                if (m_acc != '0 && m_ch == 8'h0A) begin
                    m_locked = 1'b0;
                    m_idle   = 0;
                end else if (!req_valid[m_lidx]) begin
                    m_idle++;
                    if (m_idle == LTO) begin
                        m_locked = 1'b0;
                        m_idle   = 0;
                    end
                end else begin
                    m_idle = 0;
                end
            end else if (m_acc != '0 && m_ch != 8'h0A) begin
                m_locked = 1'b1;
                m_lidx   = m_g;
                m_idle   = 0;
            end
`endif
            occ = occ + int'(m_acc != '0) - int'(m_pop);
        end
        acc_vec = m_acc;
    end

    // Requesters: hold a character until accepted, then advance.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_vec[i] && chq[i].size() > 0)
                void'(chq[i].pop_front());
            req_valid[i] = en[i] && (chq[i].size() > 0);
            req_ch[8*i +: 8] = (chq[i].size() > 0) ? chq[i][0] : 8'h00;
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            tick();
            done = (sbq.size() == 0);
            for (int i = 0; i < NREQ; i++)
                if (chq[i].size() > 0)
                    done = 1'b0;
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        sbq.delete();
        occ = 0;
        m_last = NREQ - 1;
        m_locked = 1'b0;
        m_idle = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        bit ok;
        repeat (3) @(posedge clock);
        #2;
        chk("por_req_ready", 32'(req_ready), 32'd0);
        chk("por_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_fifo_count", 32'(fifo_count), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Two requesters alternate under continuous demand.
        out_log.delete();
        for (int k = 0; k < 6; k++) begin
            chq[0].push_back(8'h41);
            chq[1].push_back(8'h42);
        end
        out_ready = 1'b1;
        en = 4'b0011;
        wait_idle(400);
`ifndef UART_ARB_LINE_LOCK_EN
        for (int k = 0; k < 4; k++) begin
            chk("rr_src", 32'(out_log[k][10:8]), 32'(k % 2));
            chk("rr_ch", 32'(out_log[k][7:0]), (k % 2) ? 32'h42 : 32'h41);
        end
`endif

        // Backpressure: nine characters into an eight-entry FIFO.
        out_log.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++)
            chq[2].push_back(8'h61 + 8'(k));
        en = 4'b0100;
        repeat (20) tick();
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_pending", 32'(chq[2].size()), 32'd1);
        out_ready = 1'b1;
        wait_idle(200);
        chk("bp_len", 32'(out_log.size()), 32'd9);
        for (int k = 0; k < 9 && k < out_log.size(); k++)
            chk("bp_order", 32'(out_log[k][7:0]), 32'h61 + 32'(k));

`ifdef UART_ARB_LINE_LOCK_EN
        // Line lock holds requester 0 through its newline.
        out_log.delete();
        chq[0].push_back(8'h68);
        chq[0].push_back(8'h69);
        chq[0].push_back(8'h0A);
        chq[1].push_back(8'h7A);
        en = 4'b0011;
        wait_idle(400);
        for (int k = 0; k < 3; k++)
            chk("lock_src", 32'(out_log[k][10:8]), 32'd0);
        chk("lock_next", 32'(out_log[3][10:8]), 32'd1);

        // Lock drops only after the timeout of idle cycles.
        chq[0].push_back(8'h78);
        en = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            ok = (chq[0].size() == 0);
        end
        chk("x_accept", 32'(ok), 32'd1);
        chq[1].push_back(8'h79);
        en = 4'b0011;
        n = 0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            n++;
            ok = req_ready[1];
        end
        chk("timeout_cycles", 32'(n), 32'(LTO));
        wait_idle(200);
`endif

        // Reset with five characters queued discards them.
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++)
            chq[0].push_back(8'h30 + 8'(k));
        en = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            ok = (occ == 5);
        end
        chk("reach_five", 32'(ok), 32'd1);
        do_reset();
        out_ready = 1'b1;
        wait_idle(300);

        // Random traffic with a mid-run reset.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 300; c++) begin
                en = NREQ'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NREQ; i++)
                    if (chq[i].size() < 2)
                        chq[i].push_back(($urandom_range(0, 3) == 0)
                                         ? 8'h0A : 8'($urandom));
                tick();
            end
            if (r == 1)
                do_reset();
        end
        en = '1;
        out_ready = 1'b1;
        wait_idle(1500);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
